// File: rtl/sram_burst_ctrl.sv
// Burst controller between a four-requester memory arbiter and an asynchronous SRAM.
// Each granted burst runs SETUP, then BURST_LEN beats of WAIT_STATES+1 ACCESS cycles.
module sram_burst_ctrl #(
  parameter int BURST_LEN   = 4,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memory_sel,
  input  logic [3:0]            grant,
  input  logic                  rwbar,
  input  logic [4*ADDR_W-1:0]   addr_bus,
  input  logic [127:0]          wdata_bus,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [31:0]           sram_dq_o,
  input  logic [31:0]           sram_dq_i,
  output logic                  sram_dq_oe,
  output logic [31:0]           rdata,
  output logic [3:0]            rdata_valid,
  output logic [3:0]            wdata_ack,
  output logic [3:0]            done,
  output logic                  err
);

  localparam int              LB        = $clog2(BURST_LEN);
  localparam logic [2:0]      WS_LAST   = 3'(WAIT_STATES);
  localparam logic [LB-1:0]   BEAT_LAST = LB'(BURST_LEN - 1);
  localparam logic [LB-1:0]   BEAT_ONE  = LB'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  logic [ADDR_W-1:0] addr_arr  [4];
  logic [31:0]       wdata_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign addr_arr[gi]  = addr_bus[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_bus[gi*32 +: 32];
    end
  endgenerate

  // Low address bits advance modulo the burst length; upper bits stay fixed.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LB-1:0]     beat);
    logic [LB-1:0] low;
    low = base[LB-1:0] + beat;
    return {base[ADDR_W-1:LB], low};
  endfunction

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic              rw_reg, rw_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [LB-1:0]     beat_reg, beat_next;
  logic [2:0]        wait_reg, wait_next;

  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              dq_oe_reg, dq_oe_next;
  logic [31:0]       dq_o_reg, dq_o_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [3:0]        rvalid_reg, rvalid_next;
  logic [3:0]        ack_reg, ack_next;
  logic [3:0]        done_reg, done_next;
  logic              err_reg, err_next;

  logic              grant_ok;
  logic [1:0]        grant_idx;
  logic              go_access;
  logic              go_ack;
  logic [ADDR_W-1:0] go_addr;

  assign grant_ok = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    rw_next        = rw_reg;
    base_next      = base_reg;
    beat_next      = beat_reg;
    wait_next      = wait_reg;
    sram_addr_next = sram_addr_reg;
    ce_n_next      = 1'b1;
    oe_n_next      = 1'b1;
    we_n_next      = 1'b1;
    dq_oe_next     = 1'b0;
    dq_o_next      = '0;
    rdata_next     = rdata_reg;
    rvalid_next    = '0;
    ack_next       = '0;
    done_next      = '0;
    err_next       = err_reg;
    go_access      = 1'b0;
    go_ack         = 1'b0;
    go_addr        = '0;

    case (state_reg)
      IDLE: begin
        if (memory_sel) begin
          if (grant_ok) begin
            state_next     = SETUP;
            idx_next       = grant_idx;
            rw_next        = rwbar;
            base_next      = addr_arr[grant_idx];
            beat_next      = '0;
            wait_next      = '0;
            ce_n_next      = 1'b0;
            sram_addr_next = addr_arr[grant_idx];
            oe_n_next      = ~rwbar;
            dq_oe_next     = ~rwbar;
            if (!rwbar) dq_o_next = wdata_arr[grant_idx];
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
        wait_next  = '0;
        go_access  = 1'b1;
        go_addr    = beat_addr(base_reg, beat_reg);
        go_ack     = (WS_LAST == 3'd0);
      end
      ACCESS: begin
        if (wait_reg != WS_LAST) begin
          wait_next = wait_reg + 3'd1;
          go_access = 1'b1;
          go_addr   = sram_addr_reg;
          go_ack    = ((wait_reg + 3'd1) == WS_LAST);
        end else begin
          if (rw_reg) begin
            rdata_next           = sram_dq_i;
            rvalid_next[idx_reg] = 1'b1;
          end
          if (beat_reg == BEAT_LAST) begin
            state_next         = DONE;
            done_next[idx_reg] = 1'b1;
          end else begin
            beat_next = beat_reg + BEAT_ONE;
            wait_next = '0;
            go_access = 1'b1;
            go_addr   = beat_addr(base_reg, beat_reg + BEAT_ONE);
            go_ack    = (WS_LAST == 3'd0);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs for the coming ACCESS cycle; the ack lands in the beat's final cycle.
    if (go_access) begin
      ce_n_next      = 1'b0;
      sram_addr_next = go_addr;
      if (rw_reg) begin
        oe_n_next = 1'b0;
      end else begin
        we_n_next         = 1'b0;
        dq_oe_next        = 1'b1;
        dq_o_next         = wdata_arr[idx_reg];
        ack_next[idx_reg] = go_ack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      rw_reg        <= 1'b0;
      base_reg      <= '0;
      beat_reg      <= '0;
      wait_reg      <= '0;
      sram_addr_reg <= '0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      dq_o_reg      <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= '0;
      ack_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      rw_reg        <= rw_next;
      base_reg      <= base_next;
      beat_reg      <= beat_next;
      wait_reg      <= wait_next;
      sram_addr_reg <= sram_addr_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      dq_oe_reg     <= dq_oe_next;
      dq_o_reg      <= dq_o_next;
      rdata_reg     <= rdata_next;
      rvalid_reg    <= rvalid_next;
      ack_reg       <= ack_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign sram_addr   = sram_addr_reg;
  assign sram_ce_n   = ce_n_reg;
  assign sram_oe_n   = oe_n_reg;
  assign sram_we_n   = we_n_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_dq_o   = dq_o_reg;
  assign rdata       = rdata_reg;
  assign rdata_valid = rvalid_reg;
  assign wdata_ack   = ack_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule
